fmap_bram_write_arbiter: RTL and testbench
==========================================

Name: fmap_bram_write_arbiter

Overview:
Shares the single local result BRAM write port (12-bit address, 256-bit data) between several feature-map/result capture requesters, e.g. L1 capture, L2 capture and the final classifier writer. Each requester presents frame-relative writes. The arbiter grants whole frames round-robin, adds a per-requester base address and registers the BRAM write. It sequences a capture run from start to the point where every enabled requester has finished its frame, then raises write_done.

Parameters:
N_REQ, 3, number of requesters (2..8).
ADDR_W, 12, BRAM address width.
DATA_W, 256, BRAM data width.

Ports:
out_stream_aclk  in  1  clock
periph_resetn  in  1  reset; asynchronous, active-low
start  in  1  begin a capture run (pulse)
req_en_mask  in  N_REQ  requesters taking part in the run; sampled on accepted start
req_valid  in  N_REQ  requester k has a write beat
req_last  in  N_REQ  beat is last of requester k's frame
req_addr  in  N_REQ*ADDR_W  frame-relative address, slice k
req_data  in  N_REQ*DATA_W  write data, slice k
req_base  in  N_REQ*ADDR_W  base address for requester k, slice k; must be stable during a run
req_ready  out  N_REQ  beat of requester k accepted this cycle when valid&ready
req_done  out  N_REQ  sticky: requester k's last beat accepted this run
bram_addr_a  out  ADDR_W  registered write address
bram_wrdata_a  out  DATA_W  registered write data
bram_we_a  out  1  registered write enable
write_done  out  1  high in FINISHED
err_overflow  out  1  sticky: a base+addr sum exceeded 2^ADDR_W-1

Behaviour:
- Reset: state=IDLE, rr_ptr=0, owner=0, enabled mask=0. All outputs are 0, including req_ready, req_done, bram_*, write_done and err_overflow. Reset mid-run aborts with no further BRAM writes.
- States: IDLE, ARB, BURST, FINISHED.
- IDLE or FINISHED with start=1:
  - latch req_en_mask;
  - clear req_done and err_overflow;
  - go to ARB, or to FINISHED if the latched mask is 0.
- start in ARB or BURST is ignored.
- ARB, eligible set E = valid & enabled & ~done:
  - the winner is the first index in E scanning rr_ptr, rr_ptr+1, ... mod N_REQ;
  - req_ready[winner]=1 combinationally in the same cycle; every other ready is 0;
  - if E is empty, all ready are 0 and the state stays ARB.
- BURST: req_ready[owner]=1 only. Other requesters stall and hold their valid/addr/data.
- Transfer on requester k (valid&ready):
  - not last, from ARB: owner=k, go to BURST;
  - not last, in BURST: stay in BURST;
  - last: req_done[k]=1, rr_ptr=(k+1) mod N_REQ;
  - after a last beat, go to FINISHED if every enabled requester is now done, else to ARB.
  - A single-beat frame (last on the first beat) never enters BURST.
- Write path: latency is 1 cycle from the transfer.
  - The cycle after a transfer: bram_we_a=1, bram_addr_a=(req_base[k]+req_addr[k]) truncated to ADDR_W, bram_wrdata_a=req_data[k].
  - The sum is computed at ADDR_W+1 bits. If bit ADDR_W is set, bram_we_a stays 0, err_overflow is set, and the beat is still accepted and counted.
  - With no transfer: bram_we_a=0, and addr/data hold their last values.
- Throughput: one beat per cycle. There is no bubble between frames: an ARB grant in the cycle right after a last beat is allowed.
- write_done is 1 exactly while in FINISHED. It drops the cycle after an accepted start.
- Requesters not in the latched mask never see ready. req_valid changes on them are ignored.
- Assertions:
  - at most one req_ready high per cycle;
  - owner is enabled and not done while in BURST.

Test Plan:
1. Reset, mask=3'b001, start, req0 sends 24 beats with addr 0..23 (last on 23), base0=0 -> 24 consecutive writes to addr 0..23 with data matching, req_done=001, write_done=1 on the cycle after the last write is accepted.
2. mask=3'b011, req0 and req1 both valid at cycle 0, 4-beat frames, base1=30 -> req0 is granted first (rr_ptr=0) and holds the port for 4 beats while req1 sees ready=0. req1 then writes 30..33 with no idle cycle in between. write_done follows req1's last beat.
3. After test 2 finishes, start again with mask=3'b011 -> req_done clears. rr_ptr=2 scans 2,0,1, so req0 wins (req2 disabled), showing rr_ptr persists across runs.
4. base2=4090, req2 writes addr 0..7 -> 6 writes to 4090..4095, the last 2 beats are accepted with bram_we_a=0, and err_overflow=1 stays set until the next start.
5. Deassert periph_resetn mid-BURST at beat 5 -> all outputs go to 0 immediately. After release, state is IDLE, and start is needed before any req_ready.
6. start with mask=0 -> write_done=1 on the next cycle and no ready is ever asserted. A start pulse during ARB leaves req_done unchanged.

Source files
------------

// File: rtl/fmap_bram_write_arbiter.sv
// Round-robin, frame-granular arbiter sharing one BRAM write port; BRAM write is registered 1 cycle after the beat transfer.
// Backpressure: only the granted requester sees ready, and the others hold their beat until their frame is granted.
module fmap_bram_write_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 256
) (
    input  logic                    out_stream_aclk,
    input  logic                    periph_resetn,
    input  logic                    start,
    input  logic [N_REQ-1:0]        req_en_mask,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ-1:0]        req_last,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ*ADDR_W-1:0] req_base,
    output logic [N_REQ-1:0]        req_ready,
    output logic [N_REQ-1:0]        req_done,
    output logic [ADDR_W-1:0]       bram_addr_a,
    output logic [DATA_W-1:0]       bram_wrdata_a,
    output logic                    bram_we_a,
    output logic                    write_done,
    output logic                    err_overflow
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ARB, BURST, FINISHED} state_t;

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, owner;
    logic [N_REQ-1:0]   en_mask, done_q;
    logic [N_REQ-1:0]   eligible;
    logic [PTR_W-1:0]   winner, xfer_idx;
    logic               win_vld;
    logic               xfer, beat_last, beat_ovf, start_ok, all_done;
    logic [ADDR_W:0]    beat_sum;
    logic [N_REQ-1:0]   done_upd;

    function automatic logic [PTR_W-1:0] rot_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) s = s - N_REQ;
        return PTR_W'(s);
    endfunction

    assign eligible = req_valid & en_mask & ~done_q;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        winner  = '0;
        win_vld = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (eligible[rot_idx(rr_ptr, i)]) begin
                winner  = rot_idx(rr_ptr, i);
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        xfer_idx  = owner;
        case (state)
            ARB: begin
                if (win_vld) begin
                    req_ready[winner] = 1'b1;
                    xfer_idx          = winner;
                end
            end
            BURST:   req_ready[owner] = 1'b1;
            default: ;
        endcase
    end

    assign xfer      = |(req_valid & req_ready);
    assign beat_last = req_last[xfer_idx];
    assign beat_sum  = {1'b0, req_base[xfer_idx*ADDR_W +: ADDR_W]}
                     + {1'b0, req_addr[xfer_idx*ADDR_W +: ADDR_W]};
    assign beat_ovf  = beat_sum[ADDR_W];
    assign done_upd  = done_q | ((xfer && beat_last) ? (N_REQ'(1) << xfer_idx) : '0);
    assign all_done  = ((done_upd & en_mask) == en_mask);
    assign start_ok  = start && ((state == IDLE) || (state == FINISHED));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, FINISHED: begin
                if (start) state_nxt = (req_en_mask == '0) ? FINISHED : ARB;
            end
            ARB: begin
                if (xfer) begin
                    if (!beat_last)    state_nxt = BURST;
                    else if (all_done) state_nxt = FINISHED;
                    else               state_nxt = ARB;
                end
            end
            BURST: begin
                if (xfer && beat_last) state_nxt = all_done ? FINISHED : ARB;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            en_mask       <= '0;
            done_q        <= '0;
            err_overflow  <= 1'b0;
            bram_we_a     <= 1'b0;
            bram_addr_a   <= '0;
            bram_wrdata_a <= '0;
        end else begin
            state     <= state_nxt;
            bram_we_a <= xfer && !beat_ovf;
            if (start_ok) begin
                en_mask      <= req_en_mask;
                done_q       <= '0;
                err_overflow <= 1'b0;
            end
            if (xfer) begin
                done_q <= done_upd;
                if (beat_last)          rr_ptr <= rot_idx(xfer_idx, 1);
                else if (state == ARB)  owner  <= xfer_idx;
                // An overflowing beat is consumed but dropped; the port keeps its last write.
                if (beat_ovf) begin
                    err_overflow <= 1'b1;
                end else begin
                    bram_addr_a   <= beat_sum[ADDR_W-1:0];
                    bram_wrdata_a <= req_data[xfer_idx*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign req_done   = done_q;
    assign write_done = (state == FINISHED);

`ifndef SYNTHESIS
    a_one_ready: assert property (@(posedge out_stream_aclk) disable iff (!periph_resetn)
        $onehot0(req_ready));
    a_owner_live: assert property (@(posedge out_stream_aclk) disable iff (!periph_resetn)
        (state == BURST) |-> (en_mask[owner] && !done_q[owner]));
`endif

endmodule

// File: tb/tb_fmap_bram_write_arbiter.sv
// Bench for fmap_bram_write_arbiter: frame table plus random runs against a cycle-level reference model.
module tb_fmap_bram_write_arbiter;
    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 256;

    logic              out_stream_aclk;
    logic              periph_resetn;
    logic              start;
    logic [N-1:0]      req_en_mask, req_valid, req_last;
    logic [N*AW-1:0]   req_addr, req_base;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready, req_done;
    logic [AW-1:0]     bram_addr_a;
    logic [DW-1:0]     bram_wrdata_a;
    logic              bram_we_a, write_done, err_overflow;

    fmap_bram_write_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .out_stream_aclk(out_stream_aclk), .periph_resetn(periph_resetn), .start(start),
        .req_en_mask(req_en_mask), .req_valid(req_valid), .req_last(req_last),
        .req_addr(req_addr), .req_data(req_data), .req_base(req_base),
        .req_ready(req_ready), .req_done(req_done), .bram_addr_a(bram_addr_a),
        .bram_wrdata_a(bram_wrdata_a), .bram_we_a(bram_we_a), .write_done(write_done),
        .err_overflow(err_overflow)
    );

    initial out_stream_aclk = 1'b0;
    always #5 out_stream_aclk = ~out_stream_aclk;

    typedef struct {
        bit         do_rst;
        logic [2:0] mask;
        int         len0, len1, len2;
        int         base2;
        int         pct;
        int         exp_writes;
        int         exp_first;
        bit         exp_err;
    } vec_t;

    vec_t vt[14];

    int n_chk = 0, n_fail = 0;
    int wr_cnt, first_addr, xfer_cnt;

    // Reference model: run flag, finished flag, frame owner (-1 = none), rotating pointer.
    bit         m_run, m_fin, m_err;
    logic [2:0] m_en, m_done;
    int         m_rr, m_owner;
    bit         e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;

    // Requester drivers
    int         rq_len[N], rq_beat[N], base[N];
    logic [2:0] rq_vld, acc;
    logic [DW-1:0] rq_dat[N];
    int         pct;
    logic       st;
    logic [2:0] st_mask;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_err = 0; m_en = '0; m_done = '0;
        m_rr = 0; m_owner = -1; e_we = 0; acc = '0;
    endtask

    task automatic drv_clear();
        for (int k = 0; k < N; k++) begin
            rq_len[k] = 0; rq_beat[k] = 0; rq_dat[k] = '0;
        end
        rq_vld = '0; acc = '0;
    endtask

    task automatic do_reset();
        periph_resetn = 1'b0;
        model_reset();
        repeat (2) @(posedge out_stream_aclk);
        #2 periph_resetn = 1'b1;
    endtask

    task automatic step();
        logic [2:0] er;
        int k;
        @(negedge out_stream_aclk);
        chk("bram_we_a", 256'(bram_we_a), 256'(e_we));
        if (e_we) begin
            chk("bram_addr_a", 256'(bram_addr_a), 256'(e_addr));
            chk("bram_wrdata_a", bram_wrdata_a, e_data);
        end
        chk("write_done", 256'(write_done), 256'(m_fin));
        chk("req_done", 256'(req_done), 256'(m_done));
        chk("err_overflow", 256'(err_overflow), 256'(m_err));
        if (bram_we_a) begin
            if (wr_cnt == 0) first_addr = int'(bram_addr_a);
            wr_cnt++;
        end
        for (int j = 0; j < N; j++) begin
            if (acc[j]) begin rq_beat[j]++; rq_vld[j] = 1'b0; end
            if (!rq_vld[j] && rq_beat[j] < rq_len[j] && int'($urandom_range(99)) < pct) begin
                rq_vld[j] = 1'b1;
                rq_dat[j] = {$urandom, $urandom, $urandom, $urandom,
                             $urandom, $urandom, $urandom, $urandom};
            end
            req_addr[j*AW +: AW] = AW'(rq_beat[j]);
            req_base[j*AW +: AW] = AW'(base[j]);
            req_data[j*DW +: DW] = rq_dat[j];
            req_last[j]          = (rq_beat[j] == rq_len[j] - 1);
        end
        req_valid   = rq_vld;
        start       = st;
        req_en_mask = st_mask;
        #1;
        er = '0;
        k  = -1;
        if (m_run) begin
            if (m_owner >= 0) k = m_owner;
            else begin
                for (int i = 0; i < N; i++) begin
                    int c = (m_rr + i) % N;
                    if (k < 0 && rq_vld[c] && m_en[c] && !m_done[c]) k = c;
                end
            end
        end
        if (k >= 0) er[k] = 1'b1;
        chk("req_ready", 256'(req_ready), 256'(er));
        acc  = er & rq_vld;
        e_we = 0;
        if (!m_run && st) begin
            m_en = st_mask; m_done = '0; m_err = 0;
            m_fin = (st_mask == 3'b000);
            m_run = (st_mask != 3'b000);
        end else if (acc != '0) begin
            int s = base[k] + rq_beat[k];
            xfer_cnt++;
            if (s > 4095) m_err = 1;
            else begin e_we = 1; e_addr = AW'(s); e_data = rq_dat[k]; end
            if (rq_beat[k] == rq_len[k] - 1) begin
                m_done[k] = 1'b1;
                m_rr      = (k + 1) % N;
                m_owner   = -1;
                if ((m_done & m_en) == m_en) begin m_run = 0; m_fin = 1; end
            end else begin
                m_owner = k;
            end
        end
    endtask

    task automatic run_to_finish(input int budget);
        for (int c = 0; c < budget && !m_fin; c++) step();
        chk("run_timeout", 256'(m_fin), 256'(1));
        step();
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        if (v.do_rst) do_reset();
        drv_clear();
        base[0] = 0; base[1] = 30; base[2] = v.base2;
        rq_len[0] = v.len0; rq_len[1] = v.len1; rq_len[2] = v.len2;
        pct = v.pct;
        wr_cnt = 0; first_addr = -1;
        st = 1'b1; st_mask = v.mask;
        step();
        st = 1'b0;
        run_to_finish(800);
        chk($sformatf("v%0d_writes", idx), 256'(wr_cnt), 256'(v.exp_writes));
        if (v.exp_first >= 0)
            chk($sformatf("v%0d_first_addr", idx), 256'(first_addr), 256'(v.exp_first));
        chk($sformatf("v%0d_err", idx), 256'(err_overflow), 256'(v.exp_err));
        chk($sformatf("v%0d_write_done", idx), 256'(write_done), 256'(1));
    endtask

    initial begin
        vt[0] = '{1'b1, 3'b001, 24, 0, 0,    0, 100, 24,    0, 1'b0};
        vt[1] = '{1'b1, 3'b011,  4, 4, 0,    0, 100,  8,    0, 1'b0};
        vt[2] = '{1'b0, 3'b011,  4, 4, 0,    0, 100,  8,    0, 1'b0};
        vt[3] = '{1'b0, 3'b100,  0, 0, 8, 4090, 100,  6, 4090, 1'b1};
        vt[4] = '{1'b0, 3'b111,  1, 1, 1,  100, 100,  3,    0, 1'b0};
        vt[5] = '{1'b0, 3'b110,  3, 3, 2,  100, 100,  5,   30, 1'b0};
        for (int i = 6; i < 14; i++) begin
            vt[i].do_rst = 1'b0;
            vt[i].mask   = 3'($urandom_range(1, 7));
            vt[i].len0   = int'($urandom_range(1, 5));
            vt[i].len1   = int'($urandom_range(1, 5));
            vt[i].len2   = int'($urandom_range(1, 5));
            vt[i].base2  = 200;
            vt[i].pct    = int'($urandom_range(30, 90));
            vt[i].exp_writes = (vt[i].mask[0] ? vt[i].len0 : 0) + (vt[i].mask[1] ? vt[i].len1 : 0)
                             + (vt[i].mask[2] ? vt[i].len2 : 0);
            vt[i].exp_first = -1;
            vt[i].exp_err   = 1'b0;
        end

        periph_resetn = 1'b0; start = 1'b0; req_en_mask = '0; req_valid = '0;
        req_last = '0; req_addr = '0; req_data = '0; req_base = '0;
        st = 1'b0; st_mask = '0; pct = 100; xfer_cnt = 0;
        for (int k = 0; k < N; k++) base[k] = 0;
        drv_clear();
        model_reset();
        #3;
        chk("rst_ready", 256'(req_ready), 256'(0));
        chk("rst_done", 256'(req_done), 256'(0));
        chk("rst_we", 256'(bram_we_a), 256'(0));
        chk("rst_addr", 256'(bram_addr_a), 256'(0));
        chk("rst_data", bram_wrdata_a, 256'(0));
        chk("rst_write_done", 256'(write_done), 256'(0));
        chk("rst_err", 256'(err_overflow), 256'(0));

        for (int i = 0; i < 14; i++) run_vec(vt[i], i);

        // Reset in the middle of a burst
        do_reset();
        drv_clear();
        base[0] = 0; rq_len[0] = 10; pct = 100; xfer_cnt = 0;
        st = 1'b1; st_mask = 3'b001;
        step();
        st = 1'b0;
        for (int c = 0; c < 50 && xfer_cnt < 5; c++) step();
        chk("midrst_reached", 256'(xfer_cnt), 256'(5));
        periph_resetn = 1'b0;
        #1;
        chk("midrst_ready", 256'(req_ready), 256'(0));
        chk("midrst_done", 256'(req_done), 256'(0));
        chk("midrst_we", 256'(bram_we_a), 256'(0));
        chk("midrst_addr", 256'(bram_addr_a), 256'(0));
        chk("midrst_data", bram_wrdata_a, 256'(0));
        chk("midrst_write_done", 256'(write_done), 256'(0));
        model_reset();
        repeat (2) @(posedge out_stream_aclk);
        #2 periph_resetn = 1'b1;
        repeat (4) step();

        // Empty mask finishes at once and never grants
        drv_clear();
        rq_len[0] = 2; rq_len[1] = 2; rq_len[2] = 2;
        st = 1'b1; st_mask = 3'b000;
        step();
        st = 1'b0;
        step();
        chk("mask0_write_done", 256'(write_done), 256'(1));
        repeat (3) step();

        // Start during ARB is ignored
        drv_clear();
        base[0] = 0; base[1] = 30; base[2] = 300;
        rq_len[0] = 2; rq_len[1] = 0; rq_len[2] = 2;
        wr_cnt = 0;
        st = 1'b1; st_mask = 3'b011;
        step();
        st = 1'b0;
        for (int c = 0; c < 50 && !m_done[0]; c++) step();
        step();
        st = 1'b1; st_mask = 3'b111;
        step();
        st = 1'b0;
        step();
        chk("arb_start_done", 256'(req_done), 256'(3'b001));
        rq_len[1] = 2; rq_beat[1] = 0;
        run_to_finish(100);
        chk("arb_start_writes", 256'(wr_cnt), 256'(4));
        chk("arb_start_write_done", 256'(write_done), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
